// File: rtl/ay_paddle_pkg.sv
// Shared types and constants for the AY-3-8500 paddle pulse decoder.
// One decoder instance per player; all of them use these definitions.
package ay_paddle_pkg;

   localparam int LINE_W = 8;
   localparam logic [LINE_W-1:0] RESET_POS_DEFAULT = 8'd128;

   typedef enum logic [1:0] {
      IDLE,
      DISCHARGE,
      MEASURE,
      DONE
   } state_e;

endpackage

// File: rtl/sync_edge.sv
// Optional flip-flop synchronizer followed by either a plain output or a
// registered rising-edge detector (STAGES = 0 bypasses the synchronizer).
module sync_edge #(
   parameter int STAGES   = 2,
   parameter bit RISE_OUT = 1'b0
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic sig_s;

   if (STAGES == 0) begin : g_bypass
      assign sig_s = d_i;
   end else begin : g_sync
      logic [STAGES-1:0] chain_q;

      // NOTE: sequential state is written with <= so every flop samples the
      // pre-edge value of its neighbour; = here would collapse the chain.
      always_ff @(posedge clk_sys) begin
         if (reset) begin
            chain_q <= '0;
         end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
               chain_q[i] <= chain_q[i-1];
            end
         end
      end

      assign sig_s = chain_q[STAGES-1];
   end

   if (RISE_OUT) begin : g_rise
      logic prev_q;

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            prev_q <= 1'b0;
         end else begin
            prev_q <= sig_s;
         end
      end

      assign q_o = sig_s & ~prev_q;
   end else begin : g_level
      assign q_o = sig_s;
   end

endmodule

// File: rtl/paddle_pulse_decoder.sv
// Counts hs lines from a vs frame start until the pot comparator fires and
// reports the count as an 8-bit bat position with a one-cycle valid strobe.
module paddle_pulse_decoder
   import ay_paddle_pkg::*;
#(
   parameter int               MAX_LINES       = 255,
   parameter int               DISCHARGE_LINES = 0,
   parameter int               SYNC_STAGES     = 2,
   parameter logic [LINE_W-1:0] RESET_POS      = RESET_POS_DEFAULT
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              hs,
   input  logic              vs,
   input  logic              pot_in,
   input  logic              invert,
   output logic              pot_discharge,
   output logic [LINE_W-1:0] position,
   output logic              valid,
   output logic              timeout
);

   localparam logic [LINE_W-1:0] MAX_L = LINE_W'(MAX_LINES);
   localparam logic [LINE_W-1:0] DIS_L = LINE_W'(DISCHARGE_LINES);
   localparam state_e START_STATE = (DISCHARGE_LINES > 0) ? DISCHARGE : MEASURE;

   logic pot_s, hs_rise, vs_rise;

   sync_edge #(.STAGES(SYNC_STAGES), .RISE_OUT(1'b0)) u_pot_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .d_i     (pot_in),
      .q_o     (pot_s)
   );

   sync_edge #(.STAGES(0), .RISE_OUT(1'b1)) u_hs_edge (
      .clk_sys (clk_sys),
      .reset   (reset),
      .d_i     (hs),
      .q_o     (hs_rise)
   );

   sync_edge #(.STAGES(0), .RISE_OUT(1'b1)) u_vs_edge (
      .clk_sys (clk_sys),
      .reset   (reset),
      .d_i     (vs),
      .q_o     (vs_rise)
   );

   state_e            state_q, state_d;
   logic [LINE_W-1:0] count_q, count_d;
   logic [LINE_W-1:0] dis_q, dis_d;
   logic [LINE_W-1:0] position_q, position_d;
   logic              timeout_q, timeout_d;
   logic              valid_q, valid_d;
   logic [LINE_W-1:0] count_inc, dis_inc, inv_mask;

   assign count_inc = count_q + 8'd1;
   assign dis_inc   = dis_q + 8'd1;
   assign inv_mask  = {LINE_W{invert}};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         dis_q      <= '0;
         position_q <= RESET_POS;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         dis_q      <= dis_d;
         position_q <= position_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      dis_d      = dis_q;
      position_d = position_q;
      timeout_d  = timeout_q;
      valid_d    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (vs_rise) begin
               count_d = '0;
               dis_d   = '0;
               state_d = START_STATE;
            end
         end

         DISCHARGE: begin
            if (vs_rise) begin
               count_d = '0;
               dis_d   = '0;
               state_d = START_STATE;
            end else if (hs_rise) begin
               if (dis_inc == DIS_L) begin
                  count_d = '0;
                  dis_d   = '0;
                  state_d = MEASURE;
               end else begin
                  dis_d = dis_inc;
               end
            end
         end

         MEASURE: begin
            // vs wins over a coincident hs: the frame restarts and that line is dropped.
            if (vs_rise) begin
               valid_d    = 1'b1;
               position_d = count_q ^ inv_mask;
               timeout_d  = 1'b1;
               count_d    = '0;
               dis_d      = '0;
               state_d    = START_STATE;
            end else if (hs_rise) begin
               if (pot_s) begin
                  valid_d    = 1'b1;
                  position_d = count_q ^ inv_mask;
                  timeout_d  = 1'b0;
                  state_d    = DONE;
               end else if (count_inc == MAX_L) begin
                  valid_d    = 1'b1;
                  position_d = MAX_L ^ inv_mask;
                  timeout_d  = 1'b1;
                  state_d    = DONE;
               end else begin
                  count_d = count_inc;
               end
            end
         end
      endcase
   end

   assign pot_discharge = (state_q == DISCHARGE);
   assign position      = position_q;
   assign timeout       = timeout_q;
   assign valid         = valid_q;

endmodule

// File: tb/tb_paddle_pulse_decoder.sv
// Scoreboard bench: a countdown encoder model drives two decoders (no discharge,
// and four discharge lines); expected results are queued per frame.
module tb_paddle_pulse_decoder;

   localparam int         MAX    = 255;
   localparam int         B_DIS  = 4;
   localparam int         B_LOAD = 14;
   localparam logic [7:0] B_POS  = 8'd10;

   logic       clk_sys = 1'b0;
   logic       reset, hs, vs, pot_a, pot_b, invert;
   logic       pd_a, valid_a, to_a, pd_b, valid_b, to_b;
   logic [7:0] pos_a, pos_b;

   always #5 clk_sys = ~clk_sys;

   paddle_pulse_decoder #(.MAX_LINES(MAX), .DISCHARGE_LINES(0), .SYNC_STAGES(2)) dut_a (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .hs            (hs),
      .vs            (vs),
      .pot_in        (pot_a),
      .invert        (invert),
      .pot_discharge (pd_a),
      .position      (pos_a),
      .valid         (valid_a),
      .timeout       (to_a)
   );

   paddle_pulse_decoder #(.MAX_LINES(MAX), .DISCHARGE_LINES(B_DIS), .SYNC_STAGES(2)) dut_b (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .hs            (hs),
      .vs            (vs),
      .pot_in        (pot_b),
      .invert        (invert),
      .pot_discharge (pd_b),
      .position      (pos_b),
      .valid         (valid_b),
      .timeout       (to_b)
   );

   int         checks = 0;
   int         errors = 0;
   logic [8:0] sb_a[$];
   logic [8:0] sb_b[$];
   int         enc_a, enc_b, dis_lines;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk_sys) begin : mon_a
      logic [8:0] e;
      if (valid_a === 1'b1) begin
         if (sb_a.size() == 0) begin
            check("a_unexpected_valid", valid_a, 0);
         end else begin
            e = sb_a.pop_front();
            check("a_position", pos_a, e[7:0]);
            check("a_timeout", to_a, e[8]);
         end
      end
   end

   always @(negedge clk_sys) begin : mon_b
      logic [8:0] e;
      if (valid_b === 1'b1) begin
         if (sb_b.size() == 0) begin
            check("b_unexpected_valid", valid_b, 0);
         end else begin
            e = sb_b.pop_front();
            check("b_position", pos_b, e[7:0]);
            check("b_timeout", to_b, e[8]);
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Frame start; the encoder loads on vs and ignores a coincident hs.
   task automatic vs_pulse(input int p, input bit with_hs);
      vs    = 1'b1;
      hs    = with_hs;
      enc_a = p;
      enc_b = B_LOAD;
      pot_a = (enc_a == 0);
      pot_b = (enc_b == 0);
      tick();
      tick();
      vs = 1'b0;
      hs = 1'b0;
      repeat (2) tick();
   endtask

   task automatic line();
      hs = 1'b1;
      if (enc_a > 0) enc_a--;
      if (enc_b > 0) enc_b--;
      pot_a = (enc_a == 0);
      pot_b = (enc_b == 0);
      @(negedge clk_sys);
      if (pd_b) dis_lines++;
      tick();
      tick();
      hs = 1'b0;
      repeat (5) tick();
   endtask

   // Full frame: queue what each decoder should report for it, then drive it.
   // A frame that never latches reports its line count, timed out, at the next vs.
   task automatic frame(input int p, input int lines, input bit with_hs);
      logic [8:0] ea;
      logic [7:0] mask;
      mask = {8{invert}};
      if (p < MAX && p < lines)        ea = {1'b0, 8'(p)};
      else if (p >= MAX && lines >= MAX) ea = {1'b1, 8'(MAX)};
      else                               ea = {1'b1, 8'(lines)};
      ea[7:0] = ea[7:0] ^ mask;
      sb_a.push_back(ea);
      if (lines > B_LOAD) sb_b.push_back({1'b0, B_POS ^ mask});
      dis_lines = 0;
      vs_pulse(p, with_hs);
      repeat (lines) line();
      check("b_discharge_lines", dis_lines, B_DIS);
   endtask

   initial begin
      reset  = 1'b1;
      hs     = 1'b0;
      vs     = 1'b0;
      pot_a  = 1'b0;
      pot_b  = 1'b0;
      invert = 1'b0;
      enc_a  = 0;
      enc_b  = 0;
      repeat (3) tick();
      @(negedge clk_sys);
      check("rst_position_a", pos_a, 128);
      check("rst_position_b", pos_b, 128);
      check("rst_valid_a", valid_a, 0);
      check("rst_timeout_a", to_a, 0);
      check("rst_discharge_a", pd_a, 0);
      check("rst_discharge_b", pd_b, 0);
      reset = 1'b0;
      tick();

      frame(100, 110, 1'b0);
      invert = 1'b1;
      frame(100, 110, 1'b0);
      invert = 1'b0;
      frame(0, 20, 1'b0);
      frame(1000, 262, 1'b0);
      frame(200, 60, 1'b0);
      frame(50, 70, 1'b0);

      // Reset in the middle of a measurement: no valid from dut_a for this frame.
      sb_b.push_back({1'b0, B_POS});
      vs_pulse(200, 1'b0);
      repeat (50) line();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk_sys);
      check("midrst_position_a", pos_a, 128);
      check("midrst_timeout_a", to_a, 0);
      repeat (20) line();
      frame(100, 110, 1'b0);

      // Cut short after 30 lines by a vs that coincides with an hs rise.
      frame(200, 30, 1'b0);
      frame(40, 50, 1'b1);

      vs_pulse(0, 1'b0);
      repeat (20) tick();
      check("a_scoreboard_drained", sb_a.size(), 0);
      check("b_scoreboard_drained", sb_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/paddle_pulse_decoder.md
# paddle_pulse_decoder

Measures the pulse-timing paddle signal the AY-3-8500 consumes: the number of scan lines between a frame start and the moment a pot/comparator line goes high. The result is an 8-bit bat position with a one-cycle valid strobe. This is the decoding end of the line-countdown paddle emulation in the top level. It serves two purposes: reading real RC paddles through USER_IN, and a loopback checker for the emulated lpIN/rpIN lines. It runs in the clk_sys domain alongside the chip's hs/vs.

## Interface
- MAX_LINES, 255: saturation count; measurement ends with timeout when reached (1..255).
- DISCHARGE_LINES, 0: hs edges pot_discharge is held after frame start before counting begins (0 = count immediately).
- SYNC_STAGES, 2: flip-flop synchronizer depth on pot_in (≥2).
- RESET_POS, 8'd128: position value after reset.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- hs  in  1  active-high horizontal sync (one line per rising edge).
- vs  in  1  active-high vertical sync (frame start on rising edge).
- pot_in  in  1  asynchronous pot comparator; high = threshold crossed.
- invert  in  1  when 1, position output is bitwise inverted.
- pot_discharge  out  1  high while the external capacitor must be discharged.
- position  out  8  last measured position (after invert).
- valid  out  1  one-cycle strobe; position/timeout updated this cycle.
- timeout  out  1  last measurement saturated or was cut short by a new frame.

## Operation
- pot_in passes through a SYNC_STAGES synchronizer. Its output is pot_s.
- Edge detect: hs_d/vs_d are registered copies. hs_rise = hs & ~hs_d and vs_rise = vs & ~vs_d.
- States: IDLE, DISCHARGE, MEASURE, DONE.
- IDLE/DONE: on vs_rise, clear line count to 0. Go to DISCHARGE if DISCHARGE_LINES>0, else MEASURE.
- DISCHARGE: pot_discharge=1. Each hs_rise increments a discharge counter. When it reaches DISCHARGE_LINES, clear the count and go to MEASURE.
- MEASURE, on hs_rise, with pot_s sampled in the detect cycle:
  - pot_s=1: latch count and go to DONE.
  - pot_s=0 and count+1==MAX_LINES: latch MAX_LINES, set timeout, go to DONE.
  - pot_s=0 otherwise: increment count.
- vs_rise while in DISCHARGE or MEASURE:
  - In MEASURE: latch count with timeout=1 and pulse valid.
  - In DISCHARGE: latch nothing.
  - Either way, restart the frame (transitions as from IDLE).
- Simultaneous vs_rise and hs_rise: vs_rise wins; that hs_rise is ignored.
- A latch pulses valid and sets position = latched ^ {8{invert}}. timeout=1 only for saturation or cut-short; a normal measurement clears it.
- invert changes take effect at the next latch only.
- Count is 8 bits and never wraps. MAX_LINES bounds it.
- pot already high at MEASURE entry gives position 0 at the first hs_rise.

## Timing
- Reset values: state IDLE, position=RESET_POS, valid=0, timeout=0, pot_discharge=0, counters 0.
- Reset mid-measurement aborts the measurement without a valid pulse.
- valid is asserted the cycle after the hs_rise (or vs_rise) detect cycle, for exactly one cycle.
- position and timeout change only in the valid cycle.
- pot_in to pot_s latency is SYNC_STAGES cycles. pot edges closer than SYNC_STAGES+1 cycles before an hs_rise may sample either way.
- Loopback correspondence: if the encoder loads P at vs rise and decrements once per hs rise, the decoder reports P, for 0≤P<MAX_LINES.
- At most one valid per frame, except when vs_rise cuts a measurement short.

## Structure
- Shared package ay_paddle_pkg: state enum (IDLE, DISCHARGE, MEASURE, DONE), default RESET_POS, and the line-count width constant (8).
- One sub-module: sync_edge. It contains the synchronizer plus registered rising-edge detector and is instantiated for pot_in (synchronized) and for hs/vs (edge only, synchronizer bypassed with depth 0).
- Intended use: one instance per player in the top level.

## Test plan
- Loopback with the countdown encoder model, P=100, invert=0: one valid per frame with position=100, timeout=0. The same run with invert=1 gives position=155.
- pot_in held high before the frame: position=0 at the first hs_rise after vs_rise, timeout=0.
- pot_in never high, MAX_LINES=255, frame of 262 lines: at line 255, position=255 and timeout=1; no further valid until the next vs_rise.
- Short frame of 60 lines with P=200: vs_rise produces valid with position=60 and timeout=1, and the new measurement proceeds normally.
- DISCHARGE_LINES=4 with the pot going high 10 hs edges after the end of discharge: pot_discharge is high for exactly 4 lines and position=10.
- Reset asserted mid-MEASURE: no valid is produced, position=128, and the next full frame measures correctly. Also apply hs_rise and vs_rise in the same cycle and check that the frame restarts with count 0.
